// File: rtl/p2s_arbiter_pkg.sv
// p2s_arbiter_pkg: shared FSM states, default word width and timing minimums for p2s_arbiter
package p2s_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, ACK, GAP} state_t;
  localparam int DEF_DATA_BITS = 64;
  localparam int MIN_START_HOLD = 2;
  localparam int MIN_GAP_CYCLES = 2;
endpackage

// File: rtl/p2s_arbiter_rr_pick.sv
// p2s_arbiter_rr_pick: first set request at or after the pointer, wrapping
module p2s_arbiter_rr_pick #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         idx,
  output logic               valid
);
  always_comb begin
    idx = '0;
    valid = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NUM_REQ]) idx = 2'((int'(ptr) + k) % NUM_REQ);
  end
endmodule

// File: rtl/p2s_arbiter.sv
// p2s_arbiter: round-robin sharing of one p2s shifter; P2S_TIMEOUT_EN adds a WAIT_BUSY watchdog with err
module p2s_arbiter
  import p2s_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int START_HOLD = 3,
  parameter int GAP_CYCLES = 2
`ifdef P2S_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         busy,
  output logic [1:0]                   grant_id,
  output logic                         p2s_start,
  output logic [DATA_BITS-1:0]         p2s_data,
  input  logic                         p2s_en
`ifdef P2S_TIMEOUT_EN
  , output logic                       err
`endif
);
  localparam logic [7:0] HOLD_LAST = 8'((START_HOLD < MIN_START_HOLD ? MIN_START_HOLD : START_HOLD) - 1);
  localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES < MIN_GAP_CYCLES ? MIN_GAP_CYCLES : GAP_CYCLES) - 1);
`ifdef P2S_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
`endif
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [1:0] ptr, ptr_nx, pick_idx, next_id;
  logic pick_valid;
  p2s_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req(req),
    .ptr(ptr),
    .idx(pick_idx),
    .valid(pick_valid)
  );
  assign next_id = (grant_id == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id + 2'd1;
  assign busy = state != IDLE;
  assign p2s_start = state == START;
  assign ack = (state == ACK) ? NUM_REQ'(1) << grant_id : '0;
`ifdef P2S_TIMEOUT_EN
  assign err = state == WAIT_BUSY && p2s_en && cnt == TO_LAST;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      grant_id <= '0;
      p2s_data <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      ptr <= ptr_nx;
      if (state == IDLE && pick_valid) begin
        grant_id <= pick_idx;
        p2s_data <= req_data[int'(pick_idx)*DATA_BITS +: DATA_BITS];
      end
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt + 8'd1;
    ptr_nx = ptr;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        state_nx = pick_valid ? START : IDLE;
      end
      START: if (cnt == HOLD_LAST) begin
        state_nx = WAIT_BUSY;
        cnt_nx = '0;
      end
`ifdef P2S_TIMEOUT_EN
      WAIT_BUSY: if (!p2s_en) begin
        state_nx = WAIT_DONE;
        cnt_nx = '0;
      end else if (cnt == TO_LAST) begin
        state_nx = GAP;
        cnt_nx = '0;
        ptr_nx = next_id;
      end
`else
      WAIT_BUSY: begin
        cnt_nx = '0;
        state_nx = p2s_en ? WAIT_BUSY : WAIT_DONE;
      end
`endif
      WAIT_DONE: begin
        cnt_nx = '0;
        state_nx = p2s_en ? ACK : WAIT_DONE;
      end
      ACK: begin
        cnt_nx = '0;
        ptr_nx = next_id;
        state_nx = GAP;
      end
      GAP: state_nx = (cnt == GAP_LAST) ? IDLE : GAP;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_p2s_arbiter.sv
// tb_p2s_arbiter: directed checks of p2s_arbiter against a behavioural shifter model
module tb_p2s_arbiter;
  logic clk = 0;
  logic rst;
  logic [1:0] req;
  logic [127:0] req_data;
  logic [1:0] ack;
  logic busy;
  logic [1:0] grant_id;
  logic p2s_start;
  logic [63:0] p2s_data;
  logic p2s_en;
`ifdef P2S_TIMEOUT_EN
  logic err;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  int drop_dly = 3;
  int low_len = 65;
  bit never_drop = 0;
  bit start_q;
  p2s_arbiter #(
    .NUM_REQ(2),
    .DATA_BITS(64),
    .START_HOLD(3),
    .GAP_CYCLES(2)
`ifdef P2S_TIMEOUT_EN
    , .TIMEOUT(20)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .busy(busy),
    .grant_id(grant_id),
    .p2s_start(p2s_start),
    .p2s_data(p2s_data),
    .p2s_en(p2s_en)
`ifdef P2S_TIMEOUT_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    p2s_en = 1;
    start_q = 0;
    forever begin
      @(posedge clk);
      #1;
      if (p2s_start && !start_q && !never_drop) begin
        repeat (drop_dly) begin
          @(posedge clk);
          #1;
        end
        p2s_en = 0;
        repeat (low_len) begin
          @(posedge clk);
          #1;
        end
        p2s_en = 1;
      end
      start_q = p2s_start;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic xfer(input string tag, input logic [1:0] id, input logic [63:0] word, input bit clr, input bit mutate);
    int starts, en_tick, ack_tick, bad_data;
    bit granted, en_low;
    starts = 0;
    en_tick = -1;
    ack_tick = -1;
    bad_data = 0;
    granted = 0;
    en_low = 0;
    for (int t = 0; t < 400 && ack_tick < 0; t++) begin
      tick;
      if (busy && !granted) begin
        granted = 1;
        chk({tag, "_gid"}, 64'(grant_id), 64'(id));
        if (mutate) begin
          req[id] = 0;
          req_data[int'(id)*64 +: 64] = ~word;
        end
      end
      if (p2s_start) starts++;
      if (granted && ack == 0 && p2s_data !== word) bad_data++;
      if (!p2s_en) en_low = 1;
      else if (en_low && en_tick < 0) en_tick = t;
      if (ack != 0) begin
        ack_tick = t;
        chk({tag, "_ack"}, 64'(ack), 64'(2'b01 << id));
        if (clr) req[id] = 0;
      end
    end
    chk({tag, "_acked"}, 64'(ack_tick >= 0), 64'd1);
    chk({tag, "_starts"}, 64'(starts), 64'd3);
    chk({tag, "_data"}, 64'(bad_data), 64'd0);
    chk({tag, "_ack_lat"}, 64'(ack_tick - en_tick), 64'd1);
    tick;
    chk({tag, "_ack1cyc"}, 64'(ack), 64'd0);
    chk({tag, "_gap1"}, 64'(busy), 64'd1);
    tick;
    chk({tag, "_gap2"}, 64'(busy), 64'd1);
    tick;
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask
  initial begin
    int acks, busys;
    bit dropped;
    rst = 0;
    req = 0;
    req_data = '0;
    repeat (3) tick;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_start", 64'(p2s_start), 64'd0);
    chk("rst_data", p2s_data, 64'd0);
`ifdef P2S_TIMEOUT_EN
    chk("rst_err", 64'(err), 64'd0);
`endif
    rst = 1;
    tick;
    chk("idle_busy", 64'(busy), 64'd0);
    req_data[63:0] = 64'hDEADBEEF_01234567;
    req = 2'b01;
    xfer("single", 2'd0, 64'hDEADBEEF_01234567, 1, 0);
    req_data = {64'h1111_2222_3333_4444, 64'hA5A5_5A5A_0F0F_F0F0};
    req = 2'b01;
    dropped = 0;
    for (int t = 0; t < 50 && !dropped; t++) begin
      tick;
      dropped = !p2s_en;
    end
    chk("rst_mid_en_low", 64'(dropped), 64'd1);
    repeat (5) tick;
    rst = 0;
    tick;
    chk("rst_mid_ack", 64'(ack), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_start", 64'(p2s_start), 64'd0);
    chk("rst_mid_data", p2s_data, 64'd0);
    req = 2'b11;
    acks = 0;
    busys = 0;
    for (int t = 0; t < 80; t++) begin
      tick;
      if (ack != 0) acks++;
      if (busy) busys++;
    end
    chk("rst_hold_acks", 64'(acks), 64'd0);
    chk("rst_hold_busy", 64'(busys), 64'd0);
    rst = 1;
    xfer("rr0", 2'd0, 64'hA5A5_5A5A_0F0F_F0F0, 0, 0);
    xfer("rr1", 2'd1, 64'h1111_2222_3333_4444, 0, 0);
    xfer("rr2", 2'd0, 64'hA5A5_5A5A_0F0F_F0F0, 0, 0);
    xfer("rr3", 2'd1, 64'h1111_2222_3333_4444, 0, 0);
    req = 2'b00;
    req_data[127:64] = 64'hCAFE_F00D_8765_4321;
    req = 2'b10;
    xfer("drop", 2'd1, 64'hCAFE_F00D_8765_4321, 0, 1);
    chk("drop_req", 64'(req), 64'd0);
    drop_dly = 1;
    req_data[63:0] = 64'h0123_4567_89AB_CDEF;
    req = 2'b01;
    xfer("early_en", 2'd0, 64'h0123_4567_89AB_CDEF, 1, 0);
    drop_dly = 3;
`ifdef P2S_TIMEOUT_EN
    begin
      int t_wb, t_err, cyc;
      bit seen_start;
      never_drop = 1;
      req = 2'b01;
      t_wb = -1;
      t_err = -1;
      acks = 0;
      seen_start = 0;
      cyc = 0;
      while (cyc < 100 && t_err < 0) begin
        tick;
        if (p2s_start) seen_start = 1;
        else if (seen_start && t_wb < 0) t_wb = cyc;
        if (ack != 0) acks++;
        if (err) begin
          t_err = cyc;
          req = 2'b11;
        end
        cyc++;
      end
      chk("to_err_seen", 64'(t_err >= 0), 64'd1);
      chk("to_err_time", 64'(t_err - t_wb), 64'd19);
      chk("to_no_ack", 64'(acks), 64'd0);
      tick;
      chk("to_err_pulse", 64'(err), 64'd0);
      repeat (3) tick;
      chk("to_next_busy", 64'(busy), 64'd1);
      chk("to_next_gid", 64'(grant_id), 64'd1);
      req = 2'b00;
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
